// File: rtl/sya_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sya_feeder_if
//  Purpose  : Bundle of configuration, activation/weight stream and PE-array
//             control signals between a tile source and sya_feeder.
//  Ports    : master - tile source side (drives Cfg*, Act*, Wgt*)
//             slave  - feeder side (drives CfgRdy, ActRdy, WgtRdy, InAct_W,
//                      InWgt_N, En, Reset, Done)
//  Revision : 1.0 - initial release
// ============================================================================
interface sya_feeder_if #(
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int CHN_WIDTH = 16,
    parameter int NUM_ROW   = 16,
    parameter int NUM_COL   = 16
) ();
    logic [CHN_WIDTH-1:0]         CfgChn;
    logic                         CfgVld;
    logic                         CfgRdy;
    logic [NUM_ROW*ACT_WIDTH-1:0] ActIn;
    logic                         ActVld;
    logic                         ActRdy;
    logic [NUM_COL*WGT_WIDTH-1:0] WgtIn;
    logic                         WgtVld;
    logic                         WgtRdy;
    logic [NUM_ROW*ACT_WIDTH-1:0] InAct_W;
    logic [NUM_COL*WGT_WIDTH-1:0] InWgt_N;
    logic [NUM_ROW*NUM_COL-1:0]   En;
    logic [NUM_ROW*NUM_COL-1:0]   Reset;
    logic                         Done;

    modport master (
        output CfgChn, CfgVld, ActIn, ActVld, WgtIn, WgtVld,
        input  CfgRdy, ActRdy, WgtRdy, InAct_W, InWgt_N, En, Reset, Done
    );

    modport slave (
        input  CfgChn, CfgVld, ActIn, ActVld, WgtIn, WgtVld,
        output CfgRdy, ActRdy, WgtRdy, InAct_W, InWgt_N, En, Reset, Done
    );
endinterface
`default_nettype wire

// File: rtl/sya_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : sya_feeder
//  Purpose  : Feeds a NUM_ROW x NUM_COL systolic array. Accepts a tile of K
//             channel beats, skews activations onto the west edge and weights
//             onto the north edge, generates per-PE accumulate enables and a
//             beat-0 accumulator clear, and pulses Done once every PE holds
//             its final partial sum.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - sya_feeder_if.slave: CfgChn/CfgVld/CfgRdy tile config,
//                    ActIn/ActVld/ActRdy and WgtIn/WgtVld/WgtRdy beat streams,
//                    InAct_W/InWgt_N skewed edge data, En/Reset per-PE
//                    controls (bit r*NUM_COL+c), Done completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module sya_feeder #(
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int CHN_WIDTH = 16,
    parameter int NUM_ROW   = 16,
    parameter int NUM_COL   = 16
) (
    input  logic          clk,
    input  logic          rst,
    sya_feeder_if.slave   bus
);

    // A beat reaches PE(r,c) r+c+1 cycles after it fires, so the control
    // pipe needs NUM_ROW+NUM_COL-1 stages; DRAIN lasts the same number of
    // cycles so the last En has been issued when DONE is entered.
    localparam int c_DEPTH = NUM_ROW + NUM_COL - 1;
    localparam int c_DRN_W = $clog2(c_DEPTH + 1);
    localparam logic [c_DRN_W-1:0] c_DRAIN_LAST = c_DRN_W'(c_DEPTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FEED  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [CHN_WIDTH-1:0] r_cfgChn;
    logic [CHN_WIDTH-1:0] r_beatCnt;
    logic [c_DRN_W-1:0]   r_drainCnt;
    logic [c_DEPTH-1:0]   r_vPipe;
    logic [c_DEPTH-1:0]   r_fPipe;

    logic                 w_fire;
    logic                 w_first;
    logic [CHN_WIDTH-1:0] w_beatNext;

    assign w_fire     = (r_state == c_FEED) & bus.ActVld & bus.WgtVld;
    // Beat counter is cleared on config accept, so a zero count marks beat 0.
    assign w_first    = w_fire & (r_beatCnt == '0);
    // Cannot wrap: the counter never exceeds the latched channel count.
    assign w_beatNext = r_beatCnt + CHN_WIDTH'(1);

    assign bus.CfgRdy = (r_state == c_IDLE);
    assign bus.ActRdy = (r_state == c_FEED) & bus.WgtVld;
    assign bus.WgtRdy = (r_state == c_FEED) & bus.ActVld;
    assign bus.Done   = (r_state == c_DONE);

    // ------------------------------------------------------------------
    // Tile sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cfgChn   <= '0;
            r_beatCnt  <= '0;
            r_drainCnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.CfgVld) begin
                        r_cfgChn  <= bus.CfgChn;
                        r_beatCnt <= '0;
                        r_state   <= (bus.CfgChn == '0) ? c_DONE : c_FEED;
                    end
                end
                c_FEED: begin
                    if (w_fire) begin
                        if (w_beatNext == r_cfgChn) begin
                            r_state    <= c_DRAIN;
                            r_drainCnt <= '0;
                        end else begin
                            r_beatCnt <= w_beatNext;
                        end
                    end
                end
                c_DRAIN: begin
                    if (r_drainCnt == c_DRAIN_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_drainCnt <= r_drainCnt + c_DRN_W'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat-valid and beat-0 flag pipes; stage k feeds every PE with r+c == k
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vPipe <= '0;
            r_fPipe <= '0;
        end else begin
            r_vPipe[0] <= w_fire;
            r_fPipe[0] <= w_first;
            for (int k = 1; k < c_DEPTH; k++) begin
                r_vPipe[k] <= r_vPipe[k-1];
                r_fPipe[k] <= r_fPipe[k-1];
            end
        end
    end

    logic [NUM_ROW*NUM_COL-1:0] w_en;
    logic [NUM_ROW*NUM_COL-1:0] w_clr;

    always_comb begin
        w_en  = '0;
        w_clr = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            for (int c = 0; c < NUM_COL; c++) begin
                w_en[r*NUM_COL+c]  = r_vPipe[r+c];
                w_clr[r*NUM_COL+c] = r_fPipe[r+c];
            end
        end
    end

    assign bus.En    = w_en;
    assign bus.Reset = w_clr;

    // ------------------------------------------------------------------
    // Data skew: lane i is delayed i+1 cycles. Stalled cycles inject zero,
    // so bubbles travel down the pipe as zero data.
    // ------------------------------------------------------------------
    logic [ACT_WIDTH-1:0] w_actLane [NUM_ROW];
    logic [WGT_WIDTH-1:0] w_wgtLane [NUM_COL];

    generate
        for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_row
            logic [ACT_WIDTH-1:0] r_sh [gr+1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k <= gr; k++) begin
                        r_sh[k] <= '0;
                    end
                end else begin
                    r_sh[0] <= w_fire ? bus.ActIn[gr*ACT_WIDTH +: ACT_WIDTH] : '0;
                    for (int k = 1; k <= gr; k++) begin
                        r_sh[k] <= r_sh[k-1];
                    end
                end
            end

            assign w_actLane[gr] = r_sh[gr];
        end

        for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_col
            logic [WGT_WIDTH-1:0] r_sh [gc+1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k <= gc; k++) begin
                        r_sh[k] <= '0;
                    end
                end else begin
                    r_sh[0] <= w_fire ? bus.WgtIn[gc*WGT_WIDTH +: WGT_WIDTH] : '0;
                    for (int k = 1; k <= gc; k++) begin
                        r_sh[k] <= r_sh[k-1];
                    end
                end
            end

            assign w_wgtLane[gc] = r_sh[gc];
        end
    endgenerate

    logic [NUM_ROW*ACT_WIDTH-1:0] w_actW;
    logic [NUM_COL*WGT_WIDTH-1:0] w_wgtN;

    always_comb begin
        w_actW = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            w_actW[r*ACT_WIDTH +: ACT_WIDTH] = w_actLane[r];
        end
    end

    always_comb begin
        w_wgtN = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            w_wgtN[c*WGT_WIDTH +: WGT_WIDTH] = w_wgtLane[c];
        end
    end

    assign bus.InAct_W = w_actW;
    assign bus.InWgt_N = w_wgtN;

endmodule
`default_nettype wire
